// File: rtl/timer_bank.sv
// timer_bank: a bank of independent prescaled timer channels behind a
// single-cycle request/response register bus.  Each channel counts
// prescaler ticks up to COMPARE, then raises its STATUS bit and either
// restarts (periodic) or disables itself (one-shot).
//
// Bus handshake: there is no ready/back-pressure.  Every cycle with
// bank_req_i=1 is accepted.  Exactly one cycle later bank_rvalid_o=1 is
// presented together with bank_rdata_o and bank_err_o.  bank_rdata_o is
// zero whenever bank_rvalid_o is low and for write responses.
// Only bank_addr_i[9:2] is decoded; the byte-lane bits are ignored.
module timer_bank #(
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int NumChannels    = 4,
    parameter int PrescalerWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    bank_req_i,
    input  logic                    bank_we_i,
    input  logic [3:0]              bank_be_i,
    input  logic [AddressWidth-1:0] bank_addr_i,
    input  logic [DataWidth-1:0]    bank_wdata_i,
    output logic                    bank_rvalid_o,
    output logic [DataWidth-1:0]    bank_rdata_o,
    output logic                    bank_err_o,
    output logic [NumChannels-1:0]  irq_o,
    output logic                    intr_o
);

    // Byte-lane merge: keep the old byte where the enable is clear.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    logic [9:0] addr;
    logic [2:0] chan_idx;
    logic [1:0] reg_sel;
    logic       chan_hit;
    logic       status_hit;
    logic       info_hit;
    logic       mapped;
    logic       wr_en;
    logic       unused_addr;

    assign addr        = bank_addr_i[9:0];
    assign chan_idx    = addr[6:4];
    assign reg_sel     = addr[3:2];
    assign chan_hit    = (addr[9:7] == 3'b000) && ({1'b0, chan_idx} < 4'(NumChannels));
    assign status_hit  = (addr[9:2] == 8'h20);
    assign info_hit    = (addr[9:2] == 8'h21);
    assign mapped      = chan_hit | status_hit | info_hit;
    assign wr_en       = bank_req_i & bank_we_i;
    assign unused_addr = ^{bank_addr_i[AddressWidth-1:10], bank_addr_i[1:0]};

    // Per-channel state flattened so the read mux can index it with a loop.
    logic [NumChannels*32-1:0] count_all;
    logic [NumChannels*32-1:0] compare_all;
    logic [NumChannels*32-1:0] prescale_all;
    logic [NumChannels*3-1:0]  ctrl_all;
    logic [NumChannels-1:0]    match;
    logic [NumChannels-1:0]    ie_vec;
    logic [NumChannels-1:0]    status_q;
    logic [NumChannels-1:0]    status_clr;

    for (genvar g = 0; g < NumChannels; g++) begin : gen_chan
        logic                      en_q;
        logic                      periodic_q;
        logic                      ie_q;
        logic [PrescalerWidth-1:0] prescale_q;
        logic [PrescalerWidth-1:0] pre_cnt_q;
        logic [31:0]               compare_q;
        logic [31:0]               count_q;
        logic                      sel;
        logic                      wr_ctrl;
        logic                      wr_ps;
        logic                      wr_cmp;
        logic                      wr_cnt;
        logic                      tick;

        assign sel     = wr_en && chan_hit && (chan_idx == 3'(g));
        assign wr_ctrl = sel && (reg_sel == 2'd0) && bank_be_i[0];
        assign wr_ps   = sel && (reg_sel == 2'd1);
        assign wr_cmp  = sel && (reg_sel == 2'd2);
        assign wr_cnt  = sel && (reg_sel == 2'd3);
        assign tick    = en_q && (pre_cnt_q == prescale_q);
        assign match[g] = tick && (count_q == compare_q);

        // Control bits; a bus write beats the one-shot auto-disable.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                en_q       <= 1'b0;
                periodic_q <= 1'b0;
                ie_q       <= 1'b0;
            end else if (wr_ctrl) begin
                {ie_q, periodic_q, en_q} <= bank_wdata_i[2:0];
            end else if (match[g] && !periodic_q) begin
                en_q <= 1'b0;
            end
        end

        // PRESCALE and COMPARE are only changed by the bus.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prescale_q <= '0;
                compare_q  <= '0;
            end else begin
                if (wr_ps)  prescale_q <= PrescalerWidth'(merge_bytes(32'(prescale_q), bank_wdata_i, bank_be_i));
                if (wr_cmp) compare_q  <= merge_bytes(compare_q, bank_wdata_i, bank_be_i);
            end
        end

        // Prescaler: held at 0 while disabled, restarts after each tick and on
        // any COUNT/PRESCALE write so a freshly loaded value gets a full period.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pre_cnt_q <= '0;
            end else if (!en_q || wr_ps || wr_cnt || tick) begin
                pre_cnt_q <= '0;
            end else begin
                pre_cnt_q <= pre_cnt_q + PrescalerWidth'(1);
            end
        end

        // Main counter; a bus write wins over the tick update.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else if (wr_cnt) begin
                count_q <= merge_bytes(count_q, bank_wdata_i, bank_be_i);
            end else if (match[g]) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
            end
        end

        assign count_all[g*32 +: 32]    = count_q;
        assign compare_all[g*32 +: 32]  = compare_q;
        assign prescale_all[g*32 +: 32] = 32'(prescale_q);
        assign ctrl_all[g*3 +: 3]       = {ie_q, periodic_q, en_q};
        assign ie_vec[g]                = ie_q;
    end

    assign status_clr = (wr_en && status_hit && bank_be_i[0]) ? bank_wdata_i[NumChannels-1:0] : '0;

    // STATUS: W1C from the bus, but a same-cycle hardware set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | match;
        end
    end

    assign irq_o  = status_q & ie_vec;
    assign intr_o = |irq_o;

    logic [31:0] rd_data;

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        rd_data = '0;
        if (chan_hit) begin
            for (int i = 0; i < NumChannels; i++) begin
                if (chan_idx == 3'(i)) begin
                    case (reg_sel)
                        2'd0: rd_data = {29'd0, ctrl_all[i*3 +: 3]};
                        2'd1: rd_data = prescale_all[i*32 +: 32];
                        2'd2: rd_data = compare_all[i*32 +: 32];
                        default: rd_data = count_all[i*32 +: 32];
                    endcase
                end
            end
        end else if (status_hit) begin
            rd_data = 32'(status_q);
        end else if (info_hit) begin
            rd_data = 32'(NumChannels);
        end
    end

    // Registered response, one cycle after every accepted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_rvalid_o <= 1'b0;
            bank_rdata_o  <= '0;
            bank_err_o    <= 1'b0;
        end else begin
            bank_rvalid_o <= bank_req_i;
            bank_err_o    <= bank_req_i & ~mapped;
            bank_rdata_o  <= (bank_req_i && !bank_we_i && mapped) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus random bus traffic, all
// checked every cycle against a behavioural model of the timer bank.
module tb_timer_bank;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          bank_req;
    logic          bank_we;
    logic [3:0]    bank_be;
    logic [31:0]   bank_addr;
    logic [31:0]   bank_wdata;
    logic          bank_rvalid;
    logic [31:0]   bank_rdata;
    logic          bank_err;
    logic [NC-1:0] irq;
    logic          intr;

    int checks = 0;
    int errors = 0;

    timer_bank dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bank_req_i   (bank_req),
        .bank_we_i    (bank_we),
        .bank_be_i    (bank_be),
        .bank_addr_i  (bank_addr),
        .bank_wdata_i (bank_wdata),
        .bank_rvalid_o(bank_rvalid),
        .bank_rdata_o (bank_rdata),
        .bank_err_o   (bank_err),
        .irq_o        (irq),
        .intr_o       (intr)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    logic        m_en  [NC];
    logic        m_per [NC];
    logic        m_ie  [NC];
    logic [15:0] m_ps  [NC];
    logic [15:0] m_pc  [NC];
    logic [31:0] m_cmp [NC];
    logic [31:0] m_cnt [NC];
    logic [NC-1:0] m_status;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0;
            m_ps[c] = 0; m_pc[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0;
        end
        m_status = '0;
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [NC-1:0] model_irq();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = m_status[c] & m_ie[c];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        int ch;
        int r;
        ch = off / 16;
        r  = (off % 16) / 4;
        if (off < 'h80) begin
            case (r)
                0: return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
                1: return 32'(m_ps[ch]);
                2: return m_cmp[ch];
                default: return m_cnt[ch];
            endcase
        end
        if (off / 4 == 'h20) return 32'(m_status);
        if (off / 4 == 'h21) return 32'(NC);
        return 32'd0;
    endfunction

    // One clock of the timer rules: response from the current state, then
    // timer progress, then bus writes which override the timer.
    task automatic model_step(input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int off;
        int ch;
        int r;
        bit chan_sel;
        bit st_sel;
        bit info_sel;
        bit mapped;
        logic [NC-1:0] set_bits;
        logic [NC-1:0] clr_bits;
        logic [31:0] old_cnt [NC];
        off      = int'(addr[9:0]);
        ch       = off / 16;
        r        = (off % 16) / 4;
        chan_sel = (off < 'h80) && (ch < NC);
        st_sel   = (off / 4 == 'h20);
        info_sel = (off / 4 == 'h21);
        mapped   = chan_sel || st_sel || info_sel;
        exp_rvalid = req;
        exp_err    = req && !mapped;
        exp_rdata  = (req && !we && mapped) ? model_read(off) : 32'd0;
        set_bits = '0;
        clr_bits = '0;
        for (int c = 0; c < NC; c++) begin
            old_cnt[c] = m_cnt[c];
            if (!m_en[c]) begin
                m_pc[c] = 0;
            end else if (m_pc[c] == m_ps[c]) begin
                m_pc[c] = 0;
                if (m_cnt[c] == m_cmp[c]) begin
                    m_cnt[c] = 0;
                    set_bits[c] = 1'b1;
                    if (!m_per[c]) m_en[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 32'd1;
                end
            end else begin
                m_pc[c] = m_pc[c] + 16'd1;
            end
        end
        if (req && we && chan_sel) begin
            case (r)
                0: if (be[0]) begin
                       m_en[ch] = wdata[0]; m_per[ch] = wdata[1]; m_ie[ch] = wdata[2];
                   end
                1: begin m_ps[ch] = 16'(byte_merge(32'(m_ps[ch]), wdata, be)); m_pc[ch] = 0; end
                2: m_cmp[ch] = byte_merge(m_cmp[ch], wdata, be);
                default: begin m_cnt[ch] = byte_merge(old_cnt[ch], wdata, be); m_pc[ch] = 0; end
            endcase
        end
        if (req && we && st_sel && be[0]) clr_bits = wdata[NC-1:0];
        m_status = (m_status & ~clr_bits) | set_bits;
    endtask

    // Driver: one bus cycle, checked against the model after the edge
    task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd);
        bank_req   = req;
        bank_we    = we;
        bank_be    = be;
        bank_addr  = addr;
        bank_wdata = wdata;
        model_step(req, we, be, addr, wdata);
        @(posedge clk);
        #1;
        check_eq("rvalid", 32'(bank_rvalid), 32'(exp_rvalid));
        check_eq("rdata", bank_rdata, exp_rdata);
        check_eq("err", 32'(bank_err), 32'(exp_err));
        check_eq("irq", 32'(irq), 32'(model_irq()));
        check_eq("intr", 32'(intr), 32'(|model_irq()));
        rd = bank_rdata;
        bank_req = 1'b0;
        bank_we  = 1'b0;
    endtask

    task automatic idle();
        logic [31:0] d;
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, d);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        cycle(1'b1, 1'b1, 4'hF, addr, data, d);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        cycle(1'b1, 1'b0, 4'h0, addr, 32'h0, data);
    endtask

    // Idle until irq[b] is seen; k is the number of edges waited, -1 on timeout
    task automatic wait_irq(input int b, input int max, output int k);
        k = 0;
        while (k < max) begin
            idle();
            k++;
            if (irq[b]) return;
        end
        k = -1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [3:0]  be;
        int k;
        int kind;
        int ch;

        // Reset
        rst = 1'b1;
        bank_req = 0; bank_we = 0; bank_be = 0; bank_addr = 0; bank_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rvalid", 32'(bank_rvalid), 32'd0);
        check_eq("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Registers read zero after reset, INFO reads channel count
        rd(32'h00, d); check_eq("ctrl0_reset", d, 32'd0);
        rd(32'h3C, d); check_eq("count3_reset", d, 32'd0);
        rd(32'h84, d); check_eq("info", d, 32'd4);
        check_eq("info_err", 32'(bank_err), 32'd0);
        rd(32'h40, d); check_eq("unmapped_rdata", d, 32'd0);
        check_eq("unmapped_err", 32'(bank_err), 32'd1);

        // Periodic ch0: (3+1)*(4+1) = 20 cycles per match
        wr(32'h04, 32'd3);
        wr(32'h08, 32'd4);
        wr(32'h00, 32'h7);
        wait_irq(0, 60, k); check_eq("ch0_first_match", 32'(k), 32'd20);
        wr(32'h80, 32'h1);
        // The clearing write consumed one of the next 20 edges
        wait_irq(0, 60, k); check_eq("ch0_second_match", 32'(k), 32'd19);
        rd(32'h0C, d); check_eq("ch0_count_after_match", d, 32'd0);
        wr(32'h00, 32'h0);
        wr(32'h80, 32'hF);

        // One-shot ch1: PRESCALE=0, COMPARE=2 -> match 3 cycles after enable
        wr(32'h18, 32'd2);
        wr(32'h10, 32'h5);
        wait_irq(1, 20, k); check_eq("ch1_oneshot_match", 32'(k), 32'd3);
        rd(32'h10, d); check_eq("ch1_ctrl_after", d, 32'h4);
        rd(32'h1C, d); check_eq("ch1_count_after", d, 32'd0);
        wr(32'h80, 32'h2);
        repeat (10) idle();
        check_eq("ch1_no_rematch", 32'(irq[1]), 32'd0);

        // STATUS W1C, and a W1C coincident with a hardware set
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h18, 32'd0);
        wr(32'h00, 32'h1);
        wr(32'h10, 32'h1);
        idle();
        rd(32'h80, d); check_eq("status_both", d, 32'h3);
        wr(32'h80, 32'h1);
        rd(32'h80, d); check_eq("status_w1c", d, 32'h2);
        wr(32'h80, 32'h2);
        wr(32'h18, 32'd2);
        wr(32'h10, 32'h1);
        idle();
        idle();
        wr(32'h80, 32'h2);
        rd(32'h80, d); check_eq("status_set_beats_clear", d, 32'h2);
        wr(32'h80, 32'hF);

        // Ch2 count wrap: FFFFFFFE -> FFFFFFFF -> 0 -> 1 -> match -> 0
        wr(32'h2C, 32'hFFFF_FFFE);
        wr(32'h28, 32'd1);
        wr(32'h20, 32'h1);
        rd(32'h2C, d); check_eq("wrap_0", d, 32'hFFFF_FFFE);
        rd(32'h2C, d); check_eq("wrap_1", d, 32'hFFFF_FFFF);
        rd(32'h2C, d); check_eq("wrap_2", d, 32'h0);
        rd(32'h2C, d); check_eq("wrap_3", d, 32'h1);
        rd(32'h2C, d); check_eq("wrap_4", d, 32'h0);
        rd(32'h80, d); check_eq("wrap_status", d, 32'h4);
        wr(32'h80, 32'hF);

        // Byte-enable write to COMPARE of ch3
        cycle(1'b1, 1'b1, 4'h1, 32'h38, 32'hAABB_CCDD, d);
        rd(32'h38, d); check_eq("byte_write", d, 32'h0000_00DD);

        // Asynchronous reset mid-count with irq high and a request pending
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd1);
        wr(32'h00, 32'h7);
        wait_irq(0, 20, k); check_eq("pre_reset_irq", 32'(k), 32'd2);
        bank_req  = 1'b1;
        bank_addr = 32'h84;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rvalid", 32'(bank_rvalid), 32'd0);
        check_eq("async_rdata", bank_rdata, 32'd0);
        check_eq("async_err", 32'(bank_err), 32'd0);
        check_eq("async_irq", 32'(irq), 32'd0);
        check_eq("async_intr", 32'(intr), 32'd0);
        @(posedge clk);
        #1;
        check_eq("dropped_response", 32'(bank_rvalid), 32'd0);
        bank_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(32'(c * 16 + r * 4), d);
                check_eq("post_reset_reg", d, 32'd0);
            end
        end
        rd(32'h80, d); check_eq("post_reset_status", d, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, NC - 1);
            be   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (kind)
                0, 1: idle();
                2: begin
                    d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                    cycle(1'b1, 1'b1, be, 32'(ch * 16), d, d);
                end
                3: begin
                    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                    cycle(1'b1, 1'b1, be, 32'(ch * 16 + 4), d, d);
                end
                4: cycle(1'b1, 1'b1, be, 32'(ch * 16 + 8), 32'($urandom_range(0, 6)), d);
                5: begin
                    d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                    : 32'($urandom_range(0, 6));
                    cycle(1'b1, 1'b1, be, 32'(ch * 16 + 12), d, d);
                end
                6: cycle(1'b1, 1'b1, be, 32'h80, 32'($urandom_range(0, 15)), d);
                7, 8: begin
                    a = ($urandom_range(0, 4) == 0) ? 32'(32'h80 + 4 * $urandom_range(0, 1))
                                                    : 32'(ch * 16 + 4 * $urandom_range(0, 3));
                    rd(a, d);
                end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_03FC) : $urandom;
                    cycle(1'b1, 1'($urandom_range(0, 1)), be, a, $urandom, d);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter DataWidth, default 32, bus data width; only 32 is supported.
REQ-002 Parameter AddressWidth, default 32, bus address width; only addr[9:0] is decoded (1 kB window).
REQ-003 Parameter NumChannels, default 4, number of independent timer channels; legal range 1..8.
REQ-004 Parameter PrescalerWidth, default 16, width of each channel's prescaler; legal range 1..32.
REQ-005 One clock (clk_i); reset is asynchronous and active-high (rst_i).
REQ-006 clk_i  input  1  system clock, all state on rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 bank_req_i  input  1  bus request, single-cycle.
REQ-009 bank_we_i  input  1  write enable, qualified by req.
REQ-010 bank_be_i  input  4  byte enables for writes.
REQ-011 bank_addr_i  input  AddressWidth  byte address.
REQ-012 bank_wdata_i  input  DataWidth  write data.
REQ-013 bank_rvalid_o  output  1  response valid, for both reads and writes.
REQ-014 bank_rdata_o  output  DataWidth  read data.
REQ-015 bank_err_o  output  1  error response, valid with rvalid.
REQ-016 irq_o  output  NumChannels  per-channel interrupt, STATUS[i] & CTRL[i].IE.
REQ-017 intr_o  output  1  OR of irq_o.

Function
REQ-018 Channel i registers sit at offset i*0x10:
- 0x0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
- 0x4 PRESCALE: low PrescalerWidth bits; other bits read 0.
- 0x8 COMPARE: 32 bits.
- 0xC COUNT: 32 bits.
REQ-019 Global registers:
- 0x80 STATUS: bits[NumChannels-1:0]; write-1-to-clear.
- 0x84 INFO: read-only, value NumChannels.
REQ-020 Any other offset, or a channel offset with index >= NumChannels, is unmapped: err=1, rdata=0, no state change.
REQ-021 Every accepted req produces rvalid=1 exactly one cycle later. No back-pressure exists; back-to-back requests give back-to-back responses.
REQ-022 Read data and err are registered and valid with rvalid. rdata is 0 when rvalid=0.
REQ-023 Writes update only the bytes whose bank_be_i bit is set. Writes to INFO are ignored, without error.
REQ-024 Prescaler pre_cnt[i] is held at 0 while EN=0. While EN=1 it counts 0..PRESCALE; the cycle with pre_cnt==PRESCALE is a tick, and pre_cnt returns to 0.
REQ-025 On a tick:
- If COUNT==COMPARE (match): COUNT<=0 and STATUS[i]<=1. If PERIODIC=0, EN<=0.
- Otherwise COUNT<=COUNT+1, wrapping from 0xFFFFFFFF to 0.
REQ-026 Match period is (PRESCALE+1)*(COMPARE+1) cycles from enable with COUNT=0. PRESCALE=0 ticks every cycle.
REQ-027 If COUNT is written above COMPARE, it counts to 0xFFFFFFFF, wraps to 0, and matches only on reaching COMPARE.
REQ-028 A bus write to COUNT or PRESCALE in the same cycle as a tick takes priority: the written value is loaded and pre_cnt<=0.
REQ-029 A hardware STATUS set and a W1C of the same bit in the same cycle leave the bit set.
REQ-030 A CTRL write to EN in the match cycle of a one-shot channel: the written value wins.
REQ-031 Channels are fully independent; simultaneous matches on several channels set all their STATUS bits.

Reset
REQ-032 While rst_i=1, regardless of clock:
- CTRL, PRESCALE, COMPARE, COUNT, pre_cnt, STATUS = 0.
- rvalid=0, rdata=0, err=0.
- irq_o=0, intr_o=0.
REQ-033 Reset asserted mid-transaction drops the pending response; the first request after deassertion is serviced normally.

Verification
REQ-034 Ch0: PRESCALE=3, COMPARE=4, CTRL=0x7 -> STATUS[0] and irq_o[0] rise 20 cycles after EN; repeat every 20 cycles; COUNT reads 0 after match.
REQ-035 Ch1 one-shot: PRESCALE=0, COMPARE=2, CTRL=0x5 -> single match after 3 cycles; CTRL.EN reads 0; COUNT holds 0; no further match.
REQ-036 STATUS=0x3, write 0x1 to 0x80 -> STATUS reads 0x2. A W1C coincident with a ch1 match leaves bit1 set.
REQ-037 Write COUNT=0xFFFFFFFE, COMPARE=1, PRESCALE=0, EN -> COUNT goes 0xFFFFFFFF, 0, 1, then match.
REQ-038 Read 0x84 -> 4, err=0. Read 0x40 with NumChannels=4 -> err=1, rdata=0. Byte write be=0x1 of 0xAABBCCDD to COMPARE=0 -> reads 0x000000DD.
REQ-039 Assert rst_i asynchronously mid-count with irq_o high -> all outputs 0 immediately; all registers read 0 after release.
